rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Parametrised multi-source transaction sequencer for the RTC's multiplexed address/data parallel bus. It accepts read/write requests from NUM_SRC clients, such as the init, reset, write and permanent-read engines. It arbitrates among them and drives the full address-phase / data-phase protocol on DATA_ADDRESS with ChipSelect, Read, Write and AoD. It returns read data and a completion strobe to the granted client, and sits between the control state machines and the RTC pins, replacing ad-hoc address/data muxing.

## Interface
Parameters:
- NUM_SRC, 4: number of requesting clients (2..8)
- ADDR_W, 8: RTC register address width
- DATA_W, 8: data width, also the width of DATA_ADDRESS; must be ≥ ADDR_W
- T_PHASE, 11: cycles the strobes stay asserted in each phase (≥1)
- T_GAP, 3: recovery cycles after each phase with strobes deasserted (≥1)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- req  in  NUM_SRC  per-client transaction request
- rw  in  NUM_SRC  per-client direction: 1 = read, 0 = write
- addr  in  NUM_SRC*ADDR_W  flattened per-client address; client i uses slice i
- wdata  in  NUM_SRC*DATA_W  flattened per-client write data
- ack  out  NUM_SRC  one-hot, one-cycle completion pulse to the served client
- rdata  out  DATA_W  last read data; held until the next read completes
- rdata_valid  out  1  one-cycle pulse coincident with ack of a read
- busy  out  1  high whenever state ≠ IDLE
- DATA_ADDRESS  inout  DATA_W  multiplexed RTC bus; high-Z unless this block drives it
- ChipSelect, Read, Write  out  1  active-low RTC strobes
- AoD  out  1  0 = address phase, 1 = data phase

## Operation
- States: IDLE → ADDR → ADDR_GAP → DATA → DATA_GAP → DONE → IDLE.
- IDLE:
  - When any req bit is high, the arbiter picks one client.
  - That client's rw, addr and wdata are latched into internal registers.
  - The state moves to ADDR.
  - Clients may change their inputs after the grant edge.
- ADDR (T_PHASE cycles):
  - ChipSelect=0, Write=0, AoD=0.
  - DATA_ADDRESS drives the latched address, zero-extended to DATA_W.
- ADDR_GAP (T_GAP cycles): ChipSelect=1, Write=1, AoD=0; the address stays driven.
- DATA (T_PHASE cycles), with ChipSelect=0, AoD=1:
  - Write: Write=0 and latched wdata driven on the bus.
  - Read: Read=0, bus high-Z, and DATA_ADDRESS is captured into rdata on the edge that ends the last DATA cycle.
- DATA_GAP (T_GAP cycles): all strobes high and the bus high-Z.
- DONE (1 cycle): ack[granted]=1; rdata_valid=1 for reads only.
- Single phase counter, width clog2(max(T_PHASE,T_GAP)); it reloads on every state entry.
- Arbitration: fixed priority by default, with the lowest index winning.
- Dropping req mid-transaction is ignored: the transaction completes and ack still pulses.
- Holding req high after ack requests another transaction, which is arbitrated again in IDLE.
- Simultaneous requests: exactly one is granted; the others wait with no loss.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE; ChipSelect=Read=Write=AoD=1; DATA_ADDRESS high-Z
  - ack=0, rdata=0, rdata_valid=0, busy=0
- Reset asserted mid-transaction aborts it immediately with no ack; latched request registers clear.
- All outputs are registered; no combinational path from req to the pins.
- Grant edge E (req sampled high in IDLE):
  - ADDR occupies cycles E+1..E+T_PHASE.
  - ack is high during cycle E+2·T_PHASE+2·T_GAP+1, i.e. cycle 29 with the defaults.
- Back-to-back:
  - The earliest next grant edge is the edge ending the DONE cycle.
  - The bus is idle (all strobes high) for the DONE cycle and the DATA_GAP before it.
- The AoD transition occurs only while ChipSelect=1. Read and Write are never low simultaneously.

## Configuration
- RTC_SEQ_ROUND_ROBIN_EN defined:
  - The arbiter is round-robin.
  - Search starts at the index after the last granted client and wraps at NUM_SRC-1 → 0.
  - The pointer resets to NUM_SRC-1, so client 0 wins the first contest.
- Not defined: fixed priority, index 0 highest; no pointer register is instantiated.

## Test plan
- Reset held low with req=4'b1111 → all strobes high, bus high-Z, busy=0, ack=0. Release → client 0 is granted on the first edge.
- Client 1 writes addr=8'h21, wdata=8'h45:
  - Bus carries 8'h21 for 11 cycles with Write=0, AoD=0.
  - Then 8'h45 for 11 cycles with Write=0, AoD=1.
  - ack=4'b0010 in cycle 29.
- Client 2 reads addr=8'h24 while the bench model drives 8'h37 during DATA:
  - Read=0 for 11 cycles, bus high-Z.
  - rdata=8'h37 and rdata_valid=1 with ack=4'b0100.
- req=4'b1010 held continuously:
  - Fixed priority gives grants 1,1,1…
  - With RTC_SEQ_ROUND_ROBIN_EN the order is 1,3,1,3.
- Reset pulled low during DATA of a write → strobes go high and the bus goes high-Z within the same cycle; no ack. After release a pending request restarts from ADDR.
- Client 0 drops req one cycle after grant → the transaction still completes with ack=4'b0001 in cycle 29; no second transaction starts.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Multi-client sequencer for the RTC multiplexed address/data bus.
// Define RTC_SEQ_ROUND_ROBIN_EN for a round-robin arbiter; default is fixed priority (index 0 highest).
module rtc_bus_sequencer #(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int T_PHASE = 11,
    parameter int T_GAP   = 3
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC-1:0]        rw,
    input  logic [NUM_SRC*ADDR_W-1:0] addr,
    input  logic [NUM_SRC*DATA_W-1:0] wdata,
    output logic [NUM_SRC-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rdata_valid,
    output logic                      busy,
    inout  wire  [DATA_W-1:0]         DATA_ADDRESS,
    output logic                      ChipSelect,
    output logic                      Read,
    output logic                      Write,
    output logic                      AoD
);

    localparam int T_MAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(T_PHASE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_GAP, S_DATA, S_DATA_GAP, S_DONE
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    gnt_q;
    logic                rw_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                cs_q, rd_q, wr_q, aod_q;
    logic                drv_en_q;
    logic [DATA_W-1:0]   drv_val_q;
    logic [NUM_SRC-1:0]  ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rv_q;
    logic                busy_q;

    logic                found;
    logic [IDX_W-1:0]    pick;
    int unsigned         j;
    logic [IDX_W-1:0]    jj;
    logic                sel_rw;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

`ifdef RTC_SEQ_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    ptr_q;
`endif

    // Arbiter: search order starts after the last grant (round-robin) or at index 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        jj    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef RTC_SEQ_ROUND_ROBIN_EN
            j = 32'(ptr_q) + 32'd1 + k;
            if (j >= 32'(NUM_SRC)) j = j - 32'(NUM_SRC);
`else
            j = k;
`endif
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_rw    = rw[IDX_W'(k)];
                sel_addr  = addr[k*ADDR_W +: ADDR_W];
                sel_wdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            aod_q     <= 1'b1;
            drv_en_q  <= 1'b0;
            drv_val_q <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RTC_SEQ_ROUND_ROBIN_EN
            ptr_q     <= IDX_W'(NUM_SRC - 1);
`endif
        end else begin
            ack_q <= '0;
            rv_q  <= 1'b0;
            case (state_q)
                // DONE arbitrates too so a held request is regranted on the edge ending DONE.
                S_IDLE, S_DONE: begin
                    if (found) begin
                        state_q   <= S_ADDR;
                        cnt_q     <= PHASE_LAST;
                        gnt_q     <= pick;
                        rw_q      <= sel_rw;
                        wdata_q   <= sel_wdata;
                        cs_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        aod_q     <= 1'b0;
                        drv_en_q  <= 1'b1;
                        drv_val_q <= DATA_W'(sel_addr);
                        busy_q    <= 1'b1;
`ifdef RTC_SEQ_ROUND_ROBIN_EN
                        ptr_q     <= pick;
`endif
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (cnt_q == '0) begin
                        state_q <= S_ADDR_GAP;
                        cnt_q   <= GAP_LAST;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ADDR_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        cnt_q   <= PHASE_LAST;
                        cs_q    <= 1'b0;
                        aod_q   <= 1'b1;
                        if (rw_q) begin
                            rd_q     <= 1'b0;
                            drv_en_q <= 1'b0;
                        end else begin
                            wr_q      <= 1'b0;
                            drv_val_q <= wdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_DATA_GAP;
                        cnt_q    <= GAP_LAST;
                        cs_q     <= 1'b1;
                        rd_q     <= 1'b1;
                        wr_q     <= 1'b1;
                        drv_en_q <= 1'b0;
                        if (rw_q) rdata_q <= DATA_ADDRESS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA_GAP: begin
                    if (cnt_q == '0) begin
                        state_q      <= S_DONE;
                        ack_q[gnt_q] <= 1'b1;
                        rv_q         <= rw_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DATA_ADDRESS = drv_en_q ? drv_val_q : 'z;
    assign ChipSelect   = cs_q;
    assign Read         = rd_q;
    assign Write        = wr_q;
    assign AoD          = aod_q;
    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign rdata_valid  = rv_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: vector table, scoreboard on ack, hand-written corner sequences.
module tb_rtc_bus_sequencer;

    localparam int TP = 11;
    localparam int TG = 3;
    localparam int ACK_N = 2*TP + 2*TG + 1;

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  req, rw, ack;
    logic [31:0] addr, wdata;
    logic [7:0]  rdata;
    logic        rdata_valid, busy, ChipSelect, Read, Write, AoD;
    wire  [7:0]  DATA_ADDRESS;
    logic [7:0]  rtc_val = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] ack;
        logic       rv;
        logic [7:0] rd;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int         c;
        logic       r;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rtc;
        logic [3:0] eack;
        logic [7:0] erd;
    } vec_t;
    vec_t vecs[7];

    rtc_bus_sequencer #(
        .NUM_SRC(4), .ADDR_W(8), .DATA_W(8), .T_PHASE(TP), .T_GAP(TG)
    ) dut (
        .clk(clk), .Reset(Reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .DATA_ADDRESS(DATA_ADDRESS), .ChipSelect(ChipSelect), .Read(Read),
        .Write(Write), .AoD(AoD)
    );

    // RTC model answers reads only while the sequencer holds Read low.
    assign DATA_ADDRESS = (!Read) ? rtc_val : 'z;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic r, input logic [7:0] rd);
        sb_t e;
        e.ack = 4'(1 << c);
        e.rv  = r;
        e.rd  = rd;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (Reset && ack != 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack: got %0h expected none", ack);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_ack", 32'(ack), 32'(e.ack));
                chk("sb_rvalid", 32'(rdata_valid), 32'(e.rv));
                chk("sb_rdata", 32'(rdata), 32'(e.rd));
            end
        end else if (Reset && rdata_valid) begin
            chk("rvalid_without_ack", 32'(rdata_valid), 32'd0);
        end
    end

    task automatic issue(input int c, input logic r, input logic [7:0] a, input logic [7:0] d);
        req[c]           = 1'b1;
        rw[c]            = r;
        addr[c*8 +: 8]   = a;
        wdata[c*8 +: 8]  = d;
    endtask

    // Called on the negedge of cycle 1 after the grant edge; walks the transaction cycle by cycle.
    task automatic track(input int c, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input int drop_at, input int stop_at);
        logic [3:0] ep;
        for (int n = 1; n <= stop_at; n++) begin
            if (n <= TP)             ep = 4'b0100;
            else if (n <= TP+TG)     ep = 4'b1110;
            else if (n <= 2*TP+TG)   ep = r ? 4'b0011 : 4'b0101;
            else                     ep = 4'b1111;
            chk($sformatf("pins@%0d", n), 32'({ChipSelect, Read, Write, AoD}), 32'(ep));
            chk($sformatf("busy@%0d", n), 32'(busy), 32'd1);
            if (n <= TP+TG)
                chk($sformatf("bus_addr@%0d", n), 32'(DATA_ADDRESS), 32'(a));
            else if (!r && n <= 2*TP+TG)
                chk($sformatf("bus_wdata@%0d", n), 32'(DATA_ADDRESS), 32'(d));
            chk($sformatf("ack@%0d", n), 32'(ack), (n == ACK_N) ? 32'(1 << c) : 32'd0);
            if (n == drop_at) begin
                req   = '0;
                rw    = ~rw;
                addr  = ~addr;
                wdata = ~wdata;
            end
            if (n < stop_at) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 1'b0, 8'h21, 8'h45, 8'h00, 4'b0010, 8'h00};
        vecs[1] = '{2, 1'b1, 8'h24, 8'h00, 8'h37, 4'b0100, 8'h37};
        vecs[2] = '{0, 1'b0, 8'h5A, 8'hA5, 8'h00, 4'b0001, 8'h37};
        vecs[3] = '{3, 1'b1, 8'hFF, 8'h00, 8'hC3, 4'b1000, 8'hC3};
        vecs[4] = '{1, 1'b1, 8'h00, 8'h11, 8'h81, 4'b0010, 8'h81};
        vecs[5] = '{3, 1'b0, 8'h80, 8'h7F, 8'h00, 4'b1000, 8'h81};
        vecs[6] = '{0, 1'b0, 8'h0F, 8'hF0, 8'h00, 4'b0001, 8'h81};

        // Reset held with all clients requesting.
        Reset = 1'b0;
        req = 4'b1111; rw = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_pins", 32'({ChipSelect, Read, Write, AoD}), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        Reset = 1'b1;
        push_exp(0, 1'b0, 8'h00);
        @(negedge clk);
        track(0, 1'b0, 8'h00, 8'h00, 1, ACK_N);
        @(negedge clk);
        chk("rst_txn_idle", 32'(busy), 32'd0);
        req = '0; rw = '0; addr = '0; wdata = '0;

        // Table of single-client transactions; each drops req one cycle after grant.
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].c, vecs[i].r, vecs[i].a, vecs[i].d);
            rtc_val = vecs[i].rtc;
            sbq.push_back('{vecs[i].eack, vecs[i].r, vecs[i].erd});
            @(negedge clk);
            track(vecs[i].c, vecs[i].r, vecs[i].a, vecs[i].d, 1, ACK_N);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_idle_busy%0d", i, k), 32'(busy), 32'd0);
                chk($sformatf("v%0d_idle_pins%0d", i, k),
                    32'({ChipSelect, Read, Write, AoD}), 32'hF);
            end
        end

        // Reset in the middle of a write data phase.
        issue(1, 1'b0, 8'h33, 8'h66);
        @(negedge clk);
        track(1, 1'b0, 8'h33, 8'h66, 0, TP+TG+4);
        Reset = 1'b0;
        #1;
        chk("abort_pins", 32'({ChipSelect, Read, Write, AoD}), 32'hF);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_ack_hold", 32'(ack), 32'd0);
        Reset = 1'b1;
        push_exp(1, 1'b0, 8'h00);
        @(negedge clk);
        track(1, 1'b0, 8'h33, 8'h66, 1, ACK_N);
        @(negedge clk);
        chk("restart_idle", 32'(busy), 32'd0);

        // Fresh reset, then two clients hold req continuously.
        Reset = 1'b0;
        req = '0;
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        issue(1, 1'b0, 8'h11, 8'hA1);
        issue(3, 1'b0, 8'h13, 8'hA3);
        begin
            int order[4];
`ifdef RTC_SEQ_ROUND_ROBIN_EN
            order = '{1, 3, 1, 3};
`else
            order = '{1, 1, 1, 1};
`endif
            for (int k = 0; k < 4; k++) push_exp(order[k], 1'b0, 8'h00);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                track(order[k], 1'b0, (order[k] == 1) ? 8'h11 : 8'h13,
                      (order[k] == 1) ? 8'hA1 : 8'hA3, (k == 3) ? ACK_N : 0, ACK_N);
                @(negedge clk);
            end
        end
        chk("hold_end_idle", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
